// File: rtl/exec_pkg.sv
// ----------------------------------------------------------------------------
// exec_pkg
//   Shared constants for the execute front-end (alu_exec_pipe) and the
//   combinational ALU it drives.
//
//   Contents:
//     XLEN_DEFAULT : default operand/result width (RV32I)
//     ALU_OP_ADD   : ALUControl / in_op encoding for addition
//     ALU_OP_SUB   : ALUControl / in_op encoding for subtraction
// ----------------------------------------------------------------------------
package exec_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

endpackage : exec_pkg

// File: rtl/alu_exec_pipe_alu.sv
// ----------------------------------------------------------------------------
// ALU
//   Combinational add/subtract unit driven by the execute pipe.
//   Results wrap modulo 2^WIDTH; the carry/borrow out is discarded.
//
//   Ports:
//     data_r1    in  WIDTH  operand 1
//     data_r2    in  WIDTH  operand 2
//     ALUControl in  1      0 = add, 1 = subtract
//     ALUResult  out WIDTH  wrapped sum or difference
//     Negative   out 1      sign bit of ALUResult
// ----------------------------------------------------------------------------
module ALU
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN_DEFAULT
) (
    input  logic [WIDTH-1:0] data_r1,
    input  logic [WIDTH-1:0] data_r2,
    input  logic             ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Negative
);

    always_comb begin
        if (ALUControl == ALU_OP_SUB) begin
            ALUResult = data_r1 - data_r2;
        end else begin
            ALUResult = data_r1 + data_r2;
        end
    end

    assign Negative = ALUResult[WIDTH-1];

endmodule : ALU

// File: rtl/alu_exec_pipe.sv
// ----------------------------------------------------------------------------
// alu_exec_pipe
//   Two-stage execute front-end between operand fetch and writeback.
//   S1 registers the operand pair and op select and feeds the combinational
//   ALU; S2 captures ALUResult/Negative and presents them downstream.
//   Both sides use a valid/ready handshake; one operation per cycle is
//   sustained while out_ready stays high, and a full pipeline that sees
//   out_ready drains, advances and accepts in the same cycle.
//
//   Optional feature (macro ALU_EXEC_ZERO_EN):
//     defined   -> extra output out_zero, a registered (result == 0) flag
//     undefined -> no out_zero port, no zero register
//
//   Ports:
//     clk          in  1     rising-edge clock
//     rst_n        in  1     asynchronous active-low reset
//     in_valid     in  1     request present
//     in_ready     out 1     request accepted this cycle
//     in_r1        in  XLEN  operand 1
//     in_r2        in  XLEN  operand 2
//     in_op        in  1     0 = add, 1 = subtract
//     flush        in  1     discard all in-flight operations
//     out_valid    out 1     result present
//     out_ready    in  1     downstream accepts result
//     out_result   out XLEN  ALU result
//     out_negative out 1     sign of result
//     out_zero     out 1     result is zero (ALU_EXEC_ZERO_EN only)
// ----------------------------------------------------------------------------
module alu_exec_pipe
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_r1,
    input  logic [XLEN-1:0] in_r2,
    input  logic            in_op,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
`ifdef ALU_EXEC_ZERO_EN
    output logic            out_negative,
    output logic            out_zero
`else
    output logic            out_negative
`endif
);

    // S1: operand register
    logic            s1_valid_q, s1_valid_d;
    logic [XLEN-1:0] s1_r1_q, s1_r1_d;
    logic [XLEN-1:0] s1_r2_q, s1_r2_d;
    logic            s1_op_q, s1_op_d;

    // S2: result register
    logic            s2_valid_q, s2_valid_d;
    logic [XLEN-1:0] s2_result_q, s2_result_d;
    logic            s2_negative_q, s2_negative_d;
`ifdef ALU_EXEC_ZERO_EN
    logic            s2_zero_q, s2_zero_d;
`endif

    logic            s2_adv;
    logic            accept;
    logic [XLEN-1:0] alu_result;
    logic            alu_negative;

    // S1 moves into S2 when S2 is empty or being drained this cycle.
    assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    // flush blocks new work so the same-cycle request is dropped, not lost
    // silently inside S1.
    assign in_ready = !flush && (!s1_valid_q || s2_adv);
    assign accept   = in_valid && in_ready;

    // ---------------- S1 -> ALU -> S2 boundary ----------------
    ALU #(
        .WIDTH (XLEN)
    ) u_alu (
        .data_r1    (s1_r1_q),
        .data_r2    (s1_r2_q),
        .ALUControl (s1_op_q),
        .ALUResult  (alu_result),
        .Negative   (alu_negative)
    );

    // Next-state for both stages. Valids are cleared by flush; data
    // registers only ever load on their stage's advance condition and
    // otherwise hold, which keeps outputs stable under backpressure.
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_r1_d       = s1_r1_q;
        s1_r2_d       = s1_r2_q;
        s1_op_d       = s1_op_q;
        s2_valid_d    = s2_valid_q;
        s2_result_d   = s2_result_q;
        s2_negative_d = s2_negative_q;
`ifdef ALU_EXEC_ZERO_EN
        s2_zero_d     = s2_zero_q;
`endif

        if (accept) begin
            s1_r1_d = in_r1;
            s1_r2_d = in_r2;
            s1_op_d = in_op;
        end

        if (s2_adv) begin
            s2_result_d   = alu_result;
            s2_negative_d = alu_negative;
`ifdef ALU_EXEC_ZERO_EN
            s2_zero_d     = (alu_result == '0);
`endif
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (s2_adv) begin
                s1_valid_d = 1'b0;
            end

            if (s2_adv) begin
                s2_valid_d = 1'b1;
            end else if (out_ready) begin
                s2_valid_d = 1'b0;
            end
        end
    end

    // ---------------- S1 register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_r1_q    <= '0;
            s1_r2_q    <= '0;
            s1_op_q    <= ALU_OP_ADD;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_r1_q    <= s1_r1_d;
            s1_r2_q    <= s1_r2_d;
            s1_op_q    <= s1_op_d;
        end
    end

    // ---------------- S2 register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q    <= 1'b0;
            s2_result_q   <= '0;
            s2_negative_q <= 1'b0;
`ifdef ALU_EXEC_ZERO_EN
            s2_zero_q     <= 1'b0;
`endif
        end else begin
            s2_valid_q    <= s2_valid_d;
            s2_result_q   <= s2_result_d;
            s2_negative_q <= s2_negative_d;
`ifdef ALU_EXEC_ZERO_EN
            s2_zero_q     <= s2_zero_d;
`endif
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_result   = s2_result_q;
    assign out_negative = s2_negative_q;
`ifdef ALU_EXEC_ZERO_EN
    assign out_zero     = s2_zero_q;
`endif

endmodule : alu_exec_pipe

// File: tb/tb_alu_exec_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_pipe
//   Self-checking bench for alu_exec_pipe: a table of directed vectors
//   streamed at full rate, plus hand-written backpressure, flush and
//   asynchronous-reset sequences.
// ----------------------------------------------------------------------------
module tb_alu_exec_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_r1;
    logic [31:0] in_r2;
    logic        in_op;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_negative;
`ifdef ALU_EXEC_ZERO_EN
    logic        out_zero;
`endif

    int errors = 0;
    int checks = 0;

    alu_exec_pipe #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_r1        (in_r1),
        .in_r2        (in_r2),
        .in_op        (in_op),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
`ifdef ALU_EXEC_ZERO_EN
        .out_negative (out_negative),
        .out_zero     (out_zero)
`else
        .out_negative (out_negative)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        op;
        logic [31:0] exp_result;
        logic        exp_neg;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // advance one clock; sampling happens 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic op);
        in_valid = v;
        in_r1    = a;
        in_r2    = b;
        in_op    = op;
    endtask

    task automatic chk_out(input string name, input logic [31:0] res, input logic neg);
        chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, ".result"}, out_result, res);
        chk({name, ".neg"}, {31'd0, out_negative}, {31'd0, neg});
`ifdef ALU_EXEC_ZERO_EN
        chk({name, ".zero"}, {31'd0, out_zero}, {31'd0, (res == 32'd0)});
`endif
    endtask

    initial begin
        vecs[0] = '{32'd10,         32'd5,  1'b0, 32'd15,         1'b0};
        vecs[1] = '{32'd15,         32'd14, 1'b0, 32'd29,         1'b0};
        vecs[2] = '{32'd15,         32'd14, 1'b1, 32'd1,          1'b0};
        vecs[3] = '{32'd4,          32'd8,  1'b1, 32'hFFFF_FFFC,  1'b1};
        vecs[4] = '{32'hFFFF_FFFF,  32'd1,  1'b0, 32'd0,          1'b0};
        vecs[5] = '{32'h8000_0000,  32'd1,  1'b1, 32'h7FFF_FFFF,  1'b0};
        vecs[6] = '{32'd0,          32'd1,  1'b1, 32'hFFFF_FFFF,  1'b1};
        vecs[7] = '{32'h7FFF_FFFF,  32'd1,  1'b0, 32'h8000_0000,  1'b1};

        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        #12;
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.out_result", out_result, 32'd0);
        chk("reset.out_negative", {31'd0, out_negative}, 32'd0);
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ALU_EXEC_ZERO_EN
        chk("reset.out_zero", {31'd0, out_zero}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full-rate stream: vector i accepted at edge i, visible after edge i+1.
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(1'b1, vecs[i].r1, vecs[i].r2, vecs[i].op);
            else       drive(1'b0, 32'd0, 32'd0, 1'b0);
            chk($sformatf("stream%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            if (i == 0) chk("stream.latency_gap", {31'd0, out_valid}, 32'd0);
            else        chk_out($sformatf("stream%0d", i - 1), vecs[i-1].exp_result, vecs[i-1].exp_neg);
        end
        tick();
        chk("stream.drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: A and B fill the pipe, C is refused until release.
        out_ready = 1'b0;
        drive(1'b1, 32'd100, 32'd1, 1'b0);
        chk("bp.ready_a", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b1, 32'd50, 32'd60, 1'b1);
        chk("bp.ready_b", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b1, 32'd7, 32'd8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("bp.full_ready", {31'd0, in_ready}, 32'd0);
            chk_out("bp.hold_a", 32'd101, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", {31'd0, in_ready}, 32'd1);
        chk_out("bp.a_before_release", 32'd101, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        chk_out("bp.b", 32'hFFFF_FFF6, 1'b1);
        tick();
        chk_out("bp.c", 32'd15, 1'b0);
        tick();
        chk("bp.empty", {31'd0, out_valid}, 32'd0);

        // Flush with the pipe full and a request offered.
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd2, 1'b0);
        tick();
        drive(1'b1, 32'd3, 32'd4, 1'b0);
        tick();
        drive(1'b1, 32'd9, 32'd9, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush.in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush.ready_after", {31'd0, in_ready}, 32'd1);
        tick();
        chk("flush.no_ghost", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 32'd20, 32'd22, 1'b1);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        chk_out("flush.next_req", 32'hFFFF_FFFE, 1'b1);
        tick();
        chk("flush.next_drained", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset asserted mid-stream, between clock edges.
        drive(1'b1, 32'd5, 32'd6, 1'b1);
        tick();
        drive(1'b1, 32'd1, 32'd1, 1'b0);
        tick();
        chk_out("arst.pre", 32'hFFFF_FFFF, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst.out_result", out_result, 32'd0);
        chk("arst.out_negative", {31'd0, out_negative}, 32'd0);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("arst.no_spurious", {31'd0, out_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule : tb_alu_exec_pipe
